axi_lite_regfile: RTL
=====================

# axi_lite_regfile

Parametrised AXI4-Lite slave register file: C_NUM_REGS read/write 32-bit-word registers at C_BASEADDR, with byte-strobe writes, independent acceptance of AW and W, and fully compliant VALID/READY handshakes on all five channels. Register contents are exported as a flat bus to user logic. It sits behind the AXI interconnect as the generic control/status block for pcores and replaces fixed four-register slaves.

## Interface
- C_BASEADDR, 32'h0000_0000, byte address of register 0; aligned to C_NUM_REGS*C_S_AXI_DATA_WIDTH/8
- C_NUM_REGS, 16, number of registers, 1..256
- C_S_AXI_ADDR_WIDTH, 32, address width
- C_S_AXI_DATA_WIDTH, 32, data width, 32 or 64
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_WIDTH/3/1  write address; AWPROT ignored
- S_AXI_AWREADY  out  1
- S_AXI_WDATA/WSTRB/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- S_AXI_WREADY  out  1
- S_AXI_BRESP/BVALID  out  2/1;  S_AXI_BREADY  in  1
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_WIDTH/3/1; ARPROT ignored
- S_AXI_ARREADY  out  1
- S_AXI_RDATA/RRESP/RVALID  out  DATA_WIDTH/2/1;  S_AXI_RREADY  in  1
- REG_OUT  out  C_NUM_REGS*DATA_WIDTH  register k at bits [k*DW +: DW]

## Operation
- Decode: offset = addr - C_BASEADDR; index = offset >> log2(DW/8); low address bits ignored. Hit iff addr >= C_BASEADDR and index < C_NUM_REGS.
- Write path states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: AWREADY=1, WREADY=1. AW only -> HAVE_AW (latch addr); W only -> HAVE_W (latch data, strb); both -> RESP with commit.
  - HAVE_AW: AWREADY=0, WREADY=1; W handshake -> RESP with commit. HAVE_W symmetric.
  - Commit: on hit, for each byte b with WSTRB[b]=1, reg[index] byte b <= WDATA byte b; other bytes unchanged. Miss: no register changes.
  - RESP: BVALID=1, AWREADY=WREADY=0; BRESP held stable; BREADY=1 -> IDLE.
- Read path states: IDLE (ARREADY=1), RESP (ARREADY=0, RVALID=1).
  - AR handshake: RDATA <= reg[index] on hit, 0 on miss; -> RESP. RDATA/RRESP held until RREADY=1 -> IDLE.
- Read and write paths independent; both may be busy concurrently.
- REG_OUT reflects register state registered, updated on commit edge.

## Timing
- Reset values: AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, BRESP=00, RVALID=0, RRESP=00, RDATA=0, all registers 0, REG_OUT=0.
- Write latency: BVALID asserted the edge after the later of AW/W handshakes; register and REG_OUT update on that same edge.
- Read latency: RVALID asserted the edge after AR handshake.
- Max throughput: one write per 2 cycles with BREADY held 1; one read per 2 cycles.
- Same-edge read handshake and write commit to same register: read returns pre-write value.
- VALID never depends combinationally on READY; READY outputs are registered/state-decoded only.
- ARESETN low mid-transaction: all in-flight transactions dropped, outputs return to reset values next edge, registers cleared.

## Configuration
- AXIL_REGFILE_SLVERR_EN defined: miss accesses return BRESP/RRESP=2'b10 (SLVERR), RDATA=0.
- Not defined: misses return OKAY (2'b00), RDATA=0, write dropped silently.
- Hits always OKAY in both builds.

## Test plan
- Reset release, no traffic -> AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0, REG_OUT=0.
- AW+W same cycle, addr BASE+0x8, data 0xDEADBEEF, strb 0xF, BREADY=1 -> BVALID next cycle, BRESP=00; read BASE+0x8 -> RDATA=0xDEADBEEF one cycle after AR.
- W issued 3 cycles before AW (BASE+0x4, data 0x11223344, strb 0x5) over reg 0xFFFFFFFF -> WREADY low after W; reg reads 0xFF22FF44.
- BREADY held 0 for 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout; next write accepted only after B handshake.
- Write/read to BASE+C_NUM_REGS*4 -> no register change; BRESP/RRESP=10 with AXIL_REGFILE_SLVERR_EN, 00 without; RDATA=0.
- ARESETN low while in HAVE_AW and RESP -> next edge all outputs and registers at reset values; subsequent write completes normally.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
//
// AXI4-Lite slave register file with C_NUM_REGS word-sized registers starting
// at C_BASEADDR. Writes honour WSTRB per byte. AW and W may be accepted in
// either order or together. The read and write paths run independently. Every
// register is exported on REG_OUT for user logic.
//
// Optional build macro:
//   AXIL_REGFILE_SLVERR_EN - accesses that miss the register window answer
//                            SLVERR (2'b10). Without the macro they answer
//                            OKAY. In both builds such reads return zero and
//                            such writes are dropped.
//
// Ports:
//   ACLK, ARESETN       clock, synchronous active-low reset
//   S_AXI_AW*           write address channel (AWPROT ignored)
//   S_AXI_W*            write data channel
//   S_AXI_B*            write response channel
//   S_AXI_AR*           read address channel (ARPROT ignored)
//   S_AXI_R*            read data channel
//   REG_OUT             register k at bits [k*DW +: DW]
// -----------------------------------------------------------------------------
module axi_lite_regfile #(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = '0,
    parameter int                            C_NUM_REGS         = 16
) (
    input  logic                                     ACLK,
    input  logic                                     ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REG_OUT
);

    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int BYTES    = DW / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam logic [AW-1:0] NUM_REGS_A = AW'(C_NUM_REGS);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] RESP_MISS = 2'b10;
`else
    localparam logic [1:0] RESP_MISS = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_RESP} rstate_e;

    // An address below the base wraps to a huge offset after the subtraction.
    // The explicit >= test rejects it and does not rely on that wrap.
    function automatic logic addr_hit(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - C_BASEADDR;
        return (a >= C_BASEADDR) && ((off >> ADDR_LSB) < NUM_REGS_A);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
        return IDX_W'((a - C_BASEADDR) >> ADDR_LSB);
    endfunction

    logic [DW-1:0]    regs_q [C_NUM_REGS];

    wstate_e          wstate_q, wstate_d;
    logic [AW-1:0]    awaddr_q, awaddr_d;
    logic [DW-1:0]    wdata_q,  wdata_d;
    logic [BYTES-1:0] wstrb_q,  wstrb_d;
    logic [1:0]       bresp_q,  bresp_d;

    logic             commit;
    logic [AW-1:0]    c_addr;
    logic [DW-1:0]    c_data;
    logic [BYTES-1:0] c_strb;
    logic             c_hit;
    logic [IDX_W-1:0] c_idx;

    rstate_e          rstate_q, rstate_d;
    logic [DW-1:0]    rdata_q,  rdata_d;
    logic [1:0]       rresp_q,  rresp_d;

    // ---------------- write path ----------------
    always_comb begin
        // NOTE: every variable gets a default value first, so a branch that does not assign it cannot infer a latch.
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        commit   = 1'b0;
        c_addr   = awaddr_q;
        c_data   = wdata_q;
        c_strb   = wstrb_q;
        case (wstate_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    commit   = 1'b1;
                    c_addr   = S_AXI_AWADDR;
                    c_data   = S_AXI_WDATA;
                    c_strb   = S_AXI_WSTRB;
                    wstate_d = W_RESP;
                end else if (S_AXI_AWVALID) begin
                    awaddr_d = S_AXI_AWADDR;
                    wstate_d = W_HAVE_AW;
                end else if (S_AXI_WVALID) begin
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                    wstate_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (S_AXI_WVALID) begin
                    commit   = 1'b1;
                    c_data   = S_AXI_WDATA;
                    c_strb   = S_AXI_WSTRB;
                    wstate_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (S_AXI_AWVALID) begin
                    commit   = 1'b1;
                    c_addr   = S_AXI_AWADDR;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
        // The response is decided when the write commits and is held through RESP.
        if (commit) bresp_d = addr_hit(c_addr) ? RESP_OKAY : RESP_MISS;
    end

    assign c_hit = addr_hit(c_addr);
    assign c_idx = addr_idx(c_addr);

    assign S_AXI_AWREADY = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_W);
    assign S_AXI_WREADY  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_AW);
    assign S_AXI_BVALID  = (wstate_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;

    // ---------------- read path ----------------
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rstate_d = R_RESP;
                    // regs_q holds the value from before this edge, so a read
                    // in the same cycle as a commit returns the old value.
                    if (addr_hit(S_AXI_ARADDR)) begin
                        rdata_d = regs_q[addr_idx(S_AXI_ARADDR)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_MISS;
                    end
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign S_AXI_ARREADY = (rstate_q == R_IDLE);
    assign S_AXI_RVALID  = (rstate_q == R_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // ---------------- state registers ----------------
    // NOTE: sequential blocks use non-blocking assignments only, so every register samples its pre-edge inputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wstate_q <= W_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
            rstate_q <= rstate_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    // NOTE: this storage is reset on purpose. Software expects every register to read zero after reset, so it is built from flops and not from a RAM macro.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int k = 0; k < C_NUM_REGS; k++) regs_q[k] <= '0;
        end else if (commit && c_hit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (c_strb[b]) regs_q[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
            end
        end
    end

    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg_out
        assign REG_OUT[k*DW +: DW] = regs_q[k];
    end

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

endmodule
